// File: rtl/l3_arbiter.sv
// Round-robin arbiter/sequencer sharing the byte-wide L3 port; each grant moves one 32-bit LE word as 4 byte beats.
// Build option: define L3ARB_WRITE_EN to enable write transactions (otherwise every transaction is a read).
module l3_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*32-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_beat;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_idx;
  logic [AW-1:0]   r_base;
  logic            r_we;
  logic [31:0]     r_wdata;
  logic [23:0]     r_rbuf;

  logic [IW-1:0]   w_win;
  logic [AW-1:0]   w_addr;
  logic            w_we;
  logic [31:0]     w_wdata;

  // Search starts one past the last winner so every requester is reached within NREQ grants.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] rq, input logic [IW-1:0] last);
    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] sh;
    logic              hit;
    int                sel;
    dbl = {rq, rq};
    hit = 1'b0;
    sel = 0;
    for (int k = 0; k < NREQ; k++) begin
      sh = dbl >> (int'(last) + 1 + k);
      if (!hit && sh[0]) begin
        hit = 1'b1;
        sel = (int'(last) + 1 + k) % NREQ;
      end
    end
    return IW'(sel);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [7:0] wbyte(input logic [31:0] w, input logic [1:0] b);
    logic [31:0] s;
    s = w >> (8 * int'(b));
    return s[7:0];
  endfunction

  assign w_win  = rr_pick(req, r_last);
  assign w_addr = AW'(addr >> (AW * int'(w_win)));

`ifdef L3ARB_WRITE_EN
  logic [NREQ-1:0] w_we_sh;
  assign w_we_sh = we >> w_win;
  assign w_we    = w_we_sh[0];
  assign w_wdata = 32'(wdata >> (32 * int'(w_win)));
`else
  logic w_unused_wr;
  assign w_unused_wr = ^{we, wdata};
  assign w_we        = 1'b0;
  assign w_wdata     = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_beat    <= 2'd0;
      r_last    <= IW'(NREQ - 1);
      r_idx     <= '0;
      r_we      <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      rdata     <= 32'h0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h0;
    end else begin
      gnt <= '0;
      ack <= '0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state   <= XFER;
            r_beat    <= 2'd0;
            r_idx     <= w_win;
            r_base    <= w_addr;
            r_we      <= w_we;
            r_wdata   <= w_wdata;
            gnt       <= onehot(w_win);
            busy      <= 1'b1;
            mem_addr  <= w_addr;
            mem_we    <= w_we;
            mem_wdata <= w_we ? w_wdata[7:0] : 8'h0;
          end
        end
        XFER: begin
          // Read data lags the address by one cycle, so beat N delivers byte N-1.
          if (!r_we) begin
            case (r_beat)
              2'd1:    r_rbuf[7:0]   <= mem_rdata;
              2'd2:    r_rbuf[15:8]  <= mem_rdata;
              2'd3:    r_rbuf[23:16] <= mem_rdata;
              default: ;
            endcase
          end
          if (r_beat == 2'd3) begin
            r_state   <= DONE;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h0;
          end else begin
            r_beat    <= r_beat + 2'd1;
            mem_addr  <= mem_addr + AW'(1);
            mem_wdata <= r_we ? wbyte(r_wdata, r_beat + 2'd1) : 8'h0;
          end
        end
        DONE: begin
          if (!r_we) rdata <= {mem_rdata, r_rbuf};
          ack     <= onehot(r_idx);
          r_last  <= r_idx;
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
